// File: rtl/en4t2_q_pkg.sv
// Shared constants for the en4t2_q event queue and its picker.
package en4t2_q_pkg;
  localparam int unsigned CODE_W   = 2;
  localparam int unsigned N_SRC    = 4;
  localparam int unsigned RR_FIXED = 0;
  localparam int unsigned RR_ROUND = 1;
endpackage

// File: rtl/en4t2_pick.sv
// Combinational masked priority picker: first set candidate searching upward from start, wrapping.
module en4t2_pick
  import en4t2_q_pkg::*;
(
  input  logic [N_SRC-1:0]  cand,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  logic [CODE_W-1:0] pos;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N_SRC; k++) begin
      pos = start + CODE_W'(k);
      if (!any && cand[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/en4t2_q.sv
// Four-source event queue: sticky pending bits, one encoded grant per cycle, overflow flag.
module en4t2_q
  import en4t2_q_pkg::*;
#(
  parameter int unsigned RR = RR_FIXED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  req,
  input  logic              clr_ovf,
  input  logic              rdy,
  output logic [CODE_W-1:0] code,
  output logic              vld,
  output logic [N_SRC-1:0]  pend,
  output logic              ovf
);

  logic              retire;
  logic              load;
  logic [N_SRC-1:0]  ret_mask;
  logic [N_SRC-1:0]  cand;
  logic [CODE_W-1:0] ptr;
  logic [CODE_W-1:0] start;
  logic [CODE_W-1:0] pick_idx;
  logic              pick_any;

  // The bit being retired is excluded so it cannot be re-granted on the same edge.
  always_comb begin
    retire   = vld & rdy;
    load     = ~vld | rdy;
    ret_mask = '0;
    if (retire) ret_mask[code] = 1'b1;
    cand  = pend & ~ret_mask;
    start = '0;
    if (RR == RR_ROUND) start = retire ? code + CODE_W'(1) : ptr + CODE_W'(1);
  end

  en4t2_pick u_pick (
    .cand  (cand),
    .start (start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      vld  <= 1'b0;
      code <= '0;
      ovf  <= 1'b0;
      ptr  <= CODE_W'(N_SRC - 1);
    end else begin
      pend <= req | (pend & ~ret_mask);
      ovf  <= (|(req & pend & ~ret_mask)) | (ovf & ~clr_ovf);
      if (retire) ptr <= code;
      if (load) begin
        vld <= pick_any;
        if (pick_any) code <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_en4t2_q.sv
// Self-checking bench: fixed-priority and round-robin instances against a behavioural queue model.
module tb_en4t2_q;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       clr_ovf;
  logic       rdy;

  logic [1:0] code_o [2];
  logic       vld_o  [2];
  logic [3:0] pend_o [2];
  logic       ovf_o  [2];

  logic [3:0] m_pend [2];
  logic [1:0] m_code [2];
  logic       m_vld  [2];
  logic       m_ovf  [2];
  int         m_ptr  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  en4t2_q #(.RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .clr_ovf(clr_ovf), .rdy(rdy),
    .code(code_o[0]), .vld(vld_o[0]), .pend(pend_o[0]), .ovf(ovf_o[0])
  );

  en4t2_q #(.RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .clr_ovf(clr_ovf), .rdy(rdy),
    .code(code_o[1]), .vld(vld_o[1]), .pend(pend_o[1]), .ovf(ovf_o[1])
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_pend[j] = 4'b0000;
      m_code[j] = 2'd0;
      m_vld[j]  = 1'b0;
      m_ovf[j]  = 1'b0;
      m_ptr[j]  = 3;
    end
  endtask

  // Queue behaviour from the rules: retire, reload from remaining pending, sticky overflow.
  task automatic model_edge();
    for (int j = 0; j < 2; j++) begin
      bit ret;
      int rb;
      int start;
      bit found;
      int pick;
      logic [3:0] np;
      bit nov;
      ret   = m_vld[j] && rdy;
      rb    = ret ? int'(m_code[j]) : -1;
      start = (j == 1) ? ((ret ? rb : m_ptr[j]) + 1) % 4 : 0;
      found = 0;
      pick  = 0;
      for (int k = 0; k < 4; k++) begin
        int s;
        s = (start + k) % 4;
        if (!found && m_pend[j][s] && s != rb) begin
          found = 1;
          pick  = s;
        end
      end
      nov = m_ovf[j] && !clr_ovf;
      for (int i = 0; i < 4; i++) begin
        if (req[i] && m_pend[j][i] && i != rb) nov = 1;
        np[i] = req[i] || (m_pend[j][i] && i != rb);
      end
      if (!m_vld[j] || rdy) begin
        m_vld[j] = found;
        if (found) m_code[j] = 2'(pick);
      end
      if (ret) m_ptr[j] = rb;
      m_pend[j] = np;
      m_ovf[j]  = nov;
    end
  endtask

  task automatic check_all();
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("pend[%0d]", j), pend_o[j], m_pend[j]);
      chk($sformatf("vld[%0d]", j), 4'(vld_o[j]), 4'(m_vld[j]));
      chk($sformatf("code[%0d]", j), 4'(code_o[j]), 4'(m_code[j]));
      chk($sformatf("ovf[%0d]", j), 4'(ovf_o[j]), 4'(m_ovf[j]));
    end
  endtask

  task automatic step(input logic [3:0] r, input logic y, input logic c);
    req = r;
    rdy = y;
    clr_ovf = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; rdy = 1'b0; clr_ovf = 1'b0;
    model_reset();
    #3;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single event latency and accept.
    step(4'b0100, 1'b1, 1'b0);
    chk("lat_pend", pend_o[0], 4'b0100);
    chk("lat_vld_early", 4'(vld_o[0]), 4'd0);
    step(4'b0000, 1'b1, 1'b0);
    chk("lat_vld", 4'(vld_o[0]), 4'd1);
    chk("lat_code", 4'(code_o[0]), 4'd2);
    step(4'b0000, 1'b1, 1'b0);
    chk("lat_drain", 4'(vld_o[0]), 4'd0);

    // Burst of four: back-to-back grants in index order.
    step(4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(4'b0000, 1'b1, 1'b0);
      chk($sformatf("burst_code%0d", k), 4'(code_o[0]), 4'(k));
      chk($sformatf("burst_vld%0d", k), 4'(vld_o[0]), 4'd1);
    end
    step(4'b0000, 1'b1, 1'b0);
    chk("burst_end", 4'(vld_o[0]), 4'd0);

    // Round-robin alternation with two sources re-raised every cycle.
    step(4'b0011, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(4'b0011, 1'b1, 1'b0);
      chk($sformatf("rr_alt%0d", k), 4'(code_o[1]), 4'(k % 2));
    end
    for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 1'b0);

    // Stall holds the output stage.
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    chk("stall_code", 4'(code_o[0]), 4'd1);
    step(4'b0000, 1'b0, 1'b0);
    chk("stall_hold", 4'(code_o[0]), 4'd1);
    step(4'b0000, 1'b1, 1'b0);
    chk("stall_next", 4'(code_o[0]), 4'd0);
    step(4'b0000, 1'b1, 1'b0);

    // Overflow set, set-beats-clear, then clear.
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    chk("ovf_set", 4'(ovf_o[0]), 4'd1);
    step(4'b0100, 1'b0, 1'b1);
    chk("ovf_set_wins", 4'(ovf_o[0]), 4'd1);
    step(4'b0000, 1'b0, 1'b1);
    chk("ovf_clr", 4'(ovf_o[0]), 4'd0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Asynchronous reset mid-burst.
    step(4'b1011, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("mid_pend", pend_o[0], 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all();
    for (int k = 0; k < 2; k++) begin
      step(4'b0000, 1'b1, 1'b0);
      chk($sformatf("no_stale%0d", k), 4'(vld_o[0]), 4'd0);
    end
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("post_rst_code", 4'(code_o[1]), 4'd3);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
